// File: rtl/dco_pkg.sv
// Shared types and constants for the DCO frequency-locked-loop controller.
// Holds the FSM state encoding, default timing constants and the level-to-code map.
package dco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_UPDATE  = 2'd3
    } fll_state_t;

    localparam int DEF_WIN_LEN    = 256;
    localparam int DEF_SETTLE_CYC = 128;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LOCK_CNT   = 3;
    localparam int DEF_NUM_LVL    = 9;
    localparam int LVL_W          = 4;
    localparam int CODE_W         = 8;

    // Priority code per level; frequency rises monotonically with the index.
    function automatic logic [CODE_W-1:0] lvl_to_code(input logic [LVL_W-1:0] lvl);
        logic [CODE_W-1:0] code;
        case (lvl)
            4'd0:    code = 8'h00;
            4'd1:    code = 8'h80;
            4'd2:    code = 8'h40;
            4'd3:    code = 8'h20;
            4'd4:    code = 8'h10;
            4'd5:    code = 8'h08;
            4'd6:    code = 8'h04;
            4'd7:    code = 8'h02;
            4'd8:    code = 8'h01;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dco_edge_counter.sv
// Measurement window timer plus rising-edge counter for the DCO output.
// i_clear primes the history flop from i_dco so a level already high at window start is not counted.
module dco_edge_counter
    import dco_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic             i_dco,
    output logic [CNT_W-1:0] o_count,
    output logic             o_window_done
);

    localparam int TMR_W = $clog2(WIN_LEN);

    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_count;
    logic             r_hist;
    logic             w_rise;
    logic             w_last;

    assign w_rise        = i_dco && !r_hist;
    assign w_last        = (r_timer == TMR_W'(WIN_LEN - 1));
    assign o_window_done = i_run && w_last;
    assign o_count       = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_count <= '0;
            r_hist  <= 1'b0;
        end else if (i_clear) begin
            r_timer <= '0;
            r_count <= '0;
            r_hist  <= i_dco;
        end else if (i_run) begin
            r_hist  <= i_dco;
            r_timer <= r_timer + TMR_W'(1);
            // Saturate rather than wrap so an overfast DCO still reads as "too high".
            if (w_rise && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller stepping the DCO level until the edge count per window is within tolerance.
// Define DCO_FLL_CNT_OUT_EN to add the meas_cnt output holding the last completed window count.
module dco_fll_ctrl
    import dco_pkg::*;
#(
    parameter int WIN_LEN    = DEF_WIN_LEN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int NUM_LVL    = DEF_NUM_LVL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fll_en,
    input  logic              start,
    input  logic [7:0]        manual_code,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic [CNT_W-1:0]  tol,
    input  logic              dco_in,
    output logic [7:0]        dco_code,
    output logic              busy,
    output logic              locked,
    output logic              sat,
    output logic [3:0]        lvl
`ifdef DCO_FLL_CNT_OUT_EN
    ,output logic [CNT_W-1:0] meas_cnt
`endif
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LK_W  = $clog2(LOCK_CNT + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LVL - 1);

    fll_state_t         r_state;
    fll_state_t         w_state_nxt;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [LVL_W-1:0]   r_lvl;
    logic [LVL_W-1:0]   w_lvl_nxt;
    logic [CODE_W-1:0]  r_code;
    logic [LK_W-1:0]    r_lock_cnt;
    logic [LK_W-1:0]    w_lock_cnt_nxt;
    logic               r_locked;
    logic               w_locked_nxt;
    logic               r_sat;
    logic               w_sat_nxt;
    logic               w_ec_clear;
    logic               w_ec_run;
    logic [CNT_W-1:0]   w_count;
    logic               w_win_done;
    logic               w_settle_done;
    logic [CNT_W:0]     w_cnt_ext;
    logic [CNT_W:0]     w_lo;
    logic [CNT_W:0]     w_hi;

    dco_edge_counter #(
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W)
    ) u_edge_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_ec_clear),
        .i_run         (w_ec_run),
        .i_dco         (dco_in),
        .o_count       (w_count),
        .o_window_done (w_win_done)
    );

    // Tolerance band is one bit wider than the count so neither bound wraps.
    assign w_cnt_ext     = {1'b0, w_count};
    assign w_lo          = (target_cnt >= tol) ? ({1'b0, target_cnt} - {1'b0, tol}) : '0;
    assign w_hi          = {1'b0, target_cnt} + {1'b0, tol};
    assign w_settle_done = (r_settle_cnt == SET_W'(SETTLE_CYC - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_lvl_nxt      = r_lvl;
        w_lock_cnt_nxt = r_lock_cnt;
        w_locked_nxt   = r_locked;
        w_sat_nxt      = r_sat;
        w_ec_clear     = 1'b0;
        w_ec_run       = 1'b0;

        if (!fll_en) begin
            w_state_nxt    = ST_IDLE;
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_sat_nxt      = 1'b0;
            w_ec_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_done) begin
                        w_state_nxt = ST_MEASURE;
                        w_ec_clear  = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    w_ec_run = 1'b1;
                    if (w_win_done) begin
                        w_state_nxt = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (w_cnt_ext < w_lo) begin
                        w_lock_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                        if (r_lvl < LVL_MAX) begin
                            w_lvl_nxt = r_lvl + LVL_W'(1);
                            w_sat_nxt = 1'b0;
                        end else begin
                            w_sat_nxt = 1'b1;
                        end
                    end else if (w_cnt_ext > w_hi) begin
                        w_lock_cnt_nxt = '0;
                        w_locked_nxt   = 1'b0;
                        if (r_lvl > '0) begin
                            w_lvl_nxt = r_lvl - LVL_W'(1);
                            w_sat_nxt = 1'b0;
                        end else begin
                            w_sat_nxt = 1'b1;
                        end
                    end else begin
                        if (r_lock_cnt < LK_W'(LOCK_CNT)) begin
                            w_lock_cnt_nxt = r_lock_cnt + LK_W'(1);
                        end
                        w_locked_nxt = (w_lock_cnt_nxt == LK_W'(LOCK_CNT));
                        w_sat_nxt    = 1'b0;
                    end
                    // Only a new level needs the DCO to settle; otherwise keep measuring.
                    if (w_lvl_nxt != r_lvl) begin
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_MEASURE;
                        w_ec_clear  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_lvl        <= '0;
            r_code       <= '0;
            r_lock_cnt   <= '0;
            r_locked     <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lvl      <= w_lvl_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_sat      <= w_sat_nxt;
            r_code     <= fll_en ? lvl_to_code(w_lvl_nxt) : manual_code;
            if (fll_en && (r_state == ST_SETTLE)) begin
                r_settle_cnt <= r_settle_cnt + SET_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

`ifdef DCO_FLL_CNT_OUT_EN
    logic [CNT_W-1:0] r_meas_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas_cnt <= '0;
        end else if (fll_en && (r_state == ST_UPDATE)) begin
            r_meas_cnt <= w_count;
        end
    end

    assign meas_cnt = r_meas_cnt;
`endif

    assign dco_code = r_code;
    assign busy     = (r_state != ST_IDLE);
    assign locked   = r_locked;
    assign sat      = r_sat;
    assign lvl      = r_lvl;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
// Directed-sequence bench for dco_fll_ctrl with a behavioural DCO model and a level-trajectory scoreboard.
// Expected levels come from nominal edges-per-window arithmetic applied to the loop rules.
module tb_dco_fll_ctrl;

  localparam int WIN = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fll_en;
  logic       start;
  logic [7:0] manual_code;
  logic [7:0] target_cnt;
  logic [7:0] tol;
  logic       dco_in;
  logic [7:0] dco_code;
  logic       busy;
  logic       locked;
  logic       sat;
  logic [3:0] lvl;
`ifdef DCO_FLL_CNT_OUT_EN
  logic [7:0] meas_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_change = 0;
  int dco_ph = 0;
  bit mon_en = 1'b0;
  logic [3:0] prev_lvl = 4'd0;
  logic [3:0] exp_q[$];
  logic [7:0] code_tbl [0:8] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  dco_fll_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fll_en      (fll_en),
    .start       (start),
    .manual_code (manual_code),
    .target_cnt  (target_cnt),
    .tol         (tol),
    .dco_in      (dco_in),
    .dco_code    (dco_code),
    .busy        (busy),
    .locked      (locked),
    .sat         (sat),
    .lvl         (lvl)
`ifdef DCO_FLL_CNT_OUT_EN
    ,.meas_cnt   (meas_cnt)
`endif
  );

  // clock
  initial forever #5 clk = ~clk;

  // DCO half period in clk cycles for each priority code
  function automatic int half_of(input logic [7:0] c);
    case (c)
      8'h00: return 32;
      8'h80: return 24;
      8'h40: return 16;
      8'h20: return 12;
      8'h10: return 8;
      8'h08: return 7;
      8'h04: return 6;
      8'h02: return 5;
      8'h01: return 4;
      default: return 32;
    endcase
  endfunction

  // DCO model, updated away from the sampling edge
  initial begin
    dco_in = 1'b0;
    forever begin
      @(negedge clk);
      if (dco_ph >= half_of(dco_code) - 1) begin
        dco_in = ~dco_in;
        dco_ph = 0;
      end else begin
        dco_ph++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // level-change monitor / scoreboard
  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    cyc++;
    if (mon_en && (lvl !== prev_lvl)) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
      chk("lvl_step", {28'b0, lvl}, {28'b0, e});
      chk("lvl_range", {31'b0, (lvl <= 4'd8)}, 32'd1);
      last_change = cyc;
    end
    prev_lvl = lvl;
  end

  function automatic logic sig(input int which);
    case (which)
      0: return locked;
      1: return sat;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, input string tag);
    int n = 0;
    while (n < budget && sig(which) !== val) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, sig(which)}, {31'b0, val});
  endtask

  // Reference: apply the step rules to nominal edges per window for each level.
  task automatic plan(input int start_lvl, input int tgt, input int tl,
                      output int fin, output bit lk, output bit st);
    int l, c, lo, hi;
    l = start_lvl;
    lk = 1'b0;
    st = 1'b0;
    lo = (tgt > tl) ? tgt - tl : 0;
    hi = tgt + tl;
    for (int k = 0; k < 20; k++) begin
      c = WIN / (2 * half_of(code_tbl[l]));
      if (c < lo) begin
        if (l < 8) begin l++; exp_q.push_back(4'(l)); end
        else begin st = 1'b1; break; end
      end else if (c > hi) begin
        if (l > 0) begin l--; exp_q.push_back(4'(l)); end
        else begin st = 1'b1; break; end
      end else begin
        lk = 1'b1;
        break;
      end
    end
    fin = l;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int fin, t0;
    bit lk, st;
    logic [7:0] m;

    // reset with random inputs
    rst_n = 1'b0;
    fll_en = 1'b0;
    start = 1'b0;
    manual_code = 8'h00;
    target_cnt = 8'd0;
    tol = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fll_en = 1'($urandom);
      start = 1'($urandom);
      manual_code = 8'($urandom);
      target_cnt = 8'($urandom);
      tol = 8'($urandom);
    end
    chk("rst_code", {24'b0, dco_code}, 32'h00);
    chk("rst_lvl", {28'b0, lvl}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_sat", {31'b0, sat}, 32'd0);

    fll_en = 1'b1;
    start = 1'b0;
    target_cnt = 8'd16;
    tol = 8'd1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat ($urandom_range(20, 60)) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_lvl", {28'b0, lvl}, 32'd0);
    chk("idle_code", {24'b0, dco_code}, 32'h00);
    mon_en = 1'b1;

    // acquire upward to the target
    plan(0, 16, 1, fin, lk, st);
    pulse_start();
    chk("start_busy", {31'b0, busy}, 32'd1);
    wait_sig(0, 1'b1, 4000, "acq_locked");
    chk("acq_lvl", {28'b0, lvl}, fin);
    chk("acq_code", {24'b0, dco_code}, {24'b0, code_tbl[fin]});
    chk("acq_sat", {31'b0, sat}, {31'b0, st});
    chk("acq_queue_empty", exp_q.size(), 32'd0);
    chk("acq_lock_latency", {31'b0, ((cyc - last_change) >= 895) && ((cyc - last_change) <= 905)}, 32'd1);

    // loss of lock and re-acquire
    target_cnt = 8'd21;
    plan(4, 21, 1, fin, lk, st);
    wait_sig(0, 1'b0, 300, "lol_unlocked");
    chk("lol_lvl_step", {28'b0, lvl}, 32'd5);
    wait_sig(0, 1'b1, 3000, "lol_relocked");
    chk("lol_lvl", {28'b0, lvl}, fin);
    chk("lol_code", {24'b0, dco_code}, {24'b0, code_tbl[fin]});

    // saturate at the top level
    target_cnt = 8'd40;
    plan(6, 40, 1, fin, lk, st);
    wait_sig(1, 1'b1, 2000, "sath_sat");
    chk("sath_lvl", {28'b0, lvl}, fin);
    chk("sath_code", {24'b0, dco_code}, {24'b0, code_tbl[fin]});
    chk("sath_locked", {31'b0, locked}, {31'b0, lk});
    repeat (600) @(negedge clk);
    chk("sath_hold_lvl", {28'b0, lvl}, 32'd8);
    chk("sath_hold_sat", {31'b0, sat}, 32'd1);
    chk("sath_busy", {31'b0, busy}, 32'd1);

    // bypass aborts mid-window
    repeat ($urandom_range(10, 200)) @(negedge clk);
    manual_code = 8'hA5;
    fll_en = 1'b0;
    @(negedge clk);
    chk("byp_code", {24'b0, dco_code}, 32'hA5);
    chk("byp_busy", {31'b0, busy}, 32'd0);
    chk("byp_sat", {31'b0, sat}, 32'd0);
    chk("byp_locked", {31'b0, locked}, 32'd0);
    chk("byp_lvl_hold", {28'b0, lvl}, 32'd8);
    for (int i = 0; i < 4; i++) begin
      m = 8'($urandom);
      manual_code = m;
      @(negedge clk);
      chk("byp_code_rand", {24'b0, dco_code}, {24'b0, m});
    end
    pulse_start();
    chk("byp_start_ignored", {31'b0, busy}, 32'd0);
    fll_en = 1'b1;
    @(negedge clk);
    chk("resume_code", {24'b0, dco_code}, {24'b0, code_tbl[8]});
    chk("resume_idle", {31'b0, busy}, 32'd0);

    // resume from held level, descend to saturate low
    target_cnt = 8'd1;
    tol = 8'd0;
    plan(8, 1, 0, fin, lk, st);
    pulse_start();
    wait_sig(1, 1'b1, 5000, "desc_sat");
    chk("desc_lvl", {28'b0, lvl}, fin);
    chk("desc_code", {24'b0, dco_code}, {24'b0, code_tbl[fin]});
    chk("desc_locked", {31'b0, locked}, 32'd0);
    chk("desc_queue_empty", exp_q.size(), 32'd0);

    // async reset mid-acquisition
    target_cnt = 8'd16;
    tol = 8'd1;
    plan(0, 16, 1, fin, lk, st);
    pulse_start();
    repeat (600) @(negedge clk);
    chk("pre_rst_lvl_nonzero", {31'b0, (lvl != 4'd0)}, 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_code", {24'b0, dco_code}, 32'h00);
    chk("arst_lvl", {28'b0, lvl}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_locked", {31'b0, locked}, 32'd0);
    chk("arst_sat", {31'b0, sat}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // saturate low from level 0 on the first update
    target_cnt = 8'd1;
    tol = 8'd0;
    plan(0, 1, 0, fin, lk, st);
    pulse_start();
    t0 = cyc;
    wait_sig(1, 1'b1, 600, "satl_sat");
    chk("satl_latency", {31'b0, ((cyc - t0) >= 380) && ((cyc - t0) <= 392)}, 32'd1);
    chk("satl_lvl", {28'b0, lvl}, fin);
    chk("satl_code", {24'b0, dco_code}, 32'h00);
    chk("satl_flag", {31'b0, sat}, {31'b0, st});
`ifdef DCO_FLL_CNT_OUT_EN
    chk("meas_cnt_range", {31'b0, (meas_cnt >= 8'd3) && (meas_cnt <= 8'd5)}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
